// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C bus arbiter: FSM state encoding,
// I2C field widths and the round-robin pointer helper.
package i2c_arb_pkg;

   localparam int DATA_W = 32;
   localparam int NM_W   = 5;
   localparam int IDX_W  = 2;   // enough for up to 4 requesters

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARB     = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
      return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Round-robin winner select: first active request at or above i_ptr,
// wrapping modulo NUM_REQ.
module rr_pick
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   always_comb begin
      // NOTE: every output gets a default first, so no path through the loops leaves a latch.
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_valid && i_req[j] && (j == (int'(i_ptr) + k) % NUM_REQ)) begin
               o_valid     = 1'b1;
               o_onehot[j] = 1'b1;
               o_idx       = j[IDX_W-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C bus engine among NUM_REQ requesters.
// Optional transfer watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int          NUM_REQ     = 2,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
   input  logic                      clk_in,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_en,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*DATA_W-1:0] req_rdata,
   input  logic [NUM_REQ*NM_W-1:0]   req_nm,
   output logic [NUM_REQ-1:0]        req_grant,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [NUM_REQ-1:0]        req_error,
   output logic                      I2C_en,
   output logic                      I2C_wr,
   output logic [DATA_W-1:0]         I2C_wdata,
   output logic [DATA_W-1:0]         I2C_rdata,
   output logic [NM_W-1:0]           I2C_NM,
   input  logic                      I2C_done,
   input  logic                      I2C_error,
   output logic                      busy,
   output logic                      timeout_flag
);

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("i2c_bus_arbiter: NUM_REQ must be 2..4");
   end
   if (TIMEOUT_CYC == 16'd0) begin : g_bad_timeout
      $error("i2c_bus_arbiter: TIMEOUT_CYC must be non-zero");
   end

   state_t               r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
   logic [IDX_W-1:0]     r_owner, w_owner_nxt;
   logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
   logic                 r_en, w_en_nxt;
   logic                 r_wr, w_wr_nxt;
   logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;
   logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
   logic [NM_W-1:0]      r_nm, w_nm_nxt;
   logic [NUM_REQ-1:0]   r_done, w_done_nxt;
   logic [NUM_REQ-1:0]   r_error, w_error_nxt;

   logic [NUM_REQ-1:0]   w_win_onehot;
   logic [IDX_W-1:0]     w_win_idx;
   logic                 w_win_valid;
   logic                 w_sel_wr;
   logic [DATA_W-1:0]    w_sel_wdata, w_sel_rdata;
   logic [NM_W-1:0]      w_sel_nm;
   logic                 w_owner_req;
   logic                 w_tmo_hit;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .i_req    (req_en),
      .i_ptr    (r_ptr),
      .o_onehot (w_win_onehot),
      .o_idx    (w_win_idx),
      .o_valid  (w_win_valid)
   );

   always_comb begin
      w_sel_wr    = 1'b0;
      w_sel_wdata = '0;
      w_sel_rdata = '0;
      w_sel_nm    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win_onehot[i]) begin
            w_sel_wr    = req_wr[i];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            w_sel_rdata = req_rdata[i*DATA_W +: DATA_W];
            w_sel_nm    = req_nm[i*NM_W +: NM_W];
         end
      end
   end

   assign w_owner_req = |(req_en & r_grant);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_en_nxt    = r_en;
      w_wr_nxt    = r_wr;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_nm_nxt    = r_nm;
      w_done_nxt  = '0;
      w_error_nxt = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (|req_en) w_state_nxt = ST_ARB;
         end
         ST_ARB: begin
            if (w_win_valid) begin
               w_grant_nxt = w_win_onehot;
               w_owner_nxt = w_win_idx;
               w_wr_nxt    = w_sel_wr;
               w_wdata_nxt = w_sel_wdata;
               w_rdata_nxt = w_sel_rdata;
               w_nm_nxt    = w_sel_nm;
               w_en_nxt    = 1'b1;
               w_state_nxt = ST_ACTIVE;
            end else begin
               w_wr_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            // Error (engine or watchdog) outranks done; an abort raises no pulse.
            if (I2C_error || w_tmo_hit) begin
               w_error_nxt = r_grant;
               w_en_nxt    = 1'b0;
               w_state_nxt = ST_RELEASE;
            end else if (I2C_done) begin
               w_done_nxt  = r_grant;
               w_en_nxt    = 1'b0;
               w_state_nxt = ST_RELEASE;
            end else if (!w_owner_req) begin
               w_en_nxt    = 1'b0;
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!w_owner_req) begin
               w_grant_nxt = '0;
               w_ptr_nxt   = next_idx(r_owner, NUM_REQ);
               w_wr_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_en    <= 1'b0;
         r_wr    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_nm    <= '0;
         r_done  <= '0;
         r_error <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_en    <= w_en_nxt;
         r_wr    <= w_wr_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
         r_nm    <= w_nm_nxt;
         r_done  <= w_done_nxt;
         r_error <= w_error_nxt;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   logic [15:0] r_tmo_cnt;
   logic        r_tmo_flag;

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         r_tmo_cnt  <= '0;
         r_tmo_flag <= 1'b0;
      end else begin
         if (r_state == ST_ARB)         r_tmo_cnt <= '0;
         else if (r_state == ST_ACTIVE) r_tmo_cnt <= r_tmo_cnt + 16'd1;
         if (w_tmo_hit)                 r_tmo_flag <= 1'b1;
      end
   end

   // Fires on the TIMEOUT_CYC-th ACTIVE cycle.
   assign w_tmo_hit    = (r_state == ST_ACTIVE) && (r_tmo_cnt == TIMEOUT_CYC - 16'd1);
   assign timeout_flag = r_tmo_flag;
`else
   assign w_tmo_hit    = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   assign req_grant = r_grant;
   assign req_done  = r_done;
   assign req_error = r_error;
   assign I2C_en    = r_en;
   assign I2C_wr    = r_wr;
   assign I2C_wdata = r_wdata;
   assign I2C_rdata = r_rdata;
   assign I2C_NM    = r_nm;
   assign busy      = (r_state != ST_IDLE);

endmodule
